// File: rtl/ts_pkg.sv
// Shared constants and output-FSM state encoding for the TS-to-USB endpoint bridge.
package ts_pkg;

  localparam logic [7:0] TS_SYNC    = 8'h47;
  localparam int         TS_PKT_LEN = 188;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_READ     = 3'd1,
    ST_WRITE    = 3'd2,
    ST_COMMIT   = 3'd3,
    ST_WAIT_ACK = 3'd4
  } bridge_state_t;

endpackage

// File: rtl/ts_byte_fifo.sv
// Single-clock byte FIFO with registered read data (1-cycle latency) and an occupancy level.
module ts_byte_fifo #(
  parameter int AW = 9
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          wr_en,
  input  logic [7:0]    wr_data,
  input  logic          rd_en,
  output logic [7:0]    rd_data,
  output logic [AW:0]   level,
  output logic          empty
);

  localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

  logic [7:0]    mem [2**AW];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_wr;
  logic          do_rd;

  // A write into a full FIFO is still safe when a read frees a slot in the same cycle.
  assign empty = (level == '0);
  assign do_rd = rd_en && !empty;
  assign do_wr = wr_en && ((level != DEPTH) || do_rd);

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level   <= '0;
      rd_data <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) begin
        rd_ptr  <= rd_ptr + 1'b1;
        rd_data <= mem[rd_ptr];
      end
      case ({do_wr, do_rd})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/ts_usb_bridge.sv
// Buffers whole TS packets and writes them into a USB IN endpoint buffer with commit/ack handshake.
// Define TS_BRIDGE_STATS_EN to implement the four statistics counters; otherwise they read as 0.
module ts_usb_bridge
  import ts_pkg::*;
#(
  parameter int ADDR_W      = 11,
  parameter int FIFO_AW     = 9,
  parameter int PKT_LEN     = TS_PKT_LEN,
  parameter int ACK_TIMEOUT = 7,
  parameter int FLUSH_IDLE  = 4096
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              ts_strt,
  input  logic              ts_dval,
  input  logic [7:0]        ts_data,
  input  logic [ADDR_W-1:0] commit_len,
  input  logic              flush_en,
  output logic [ADDR_W-1:0] ep_in_addr,
  output logic [7:0]        ep_in_data,
  output logic              ep_in_wren,
  output logic              ep_in_commit,
  output logic [ADDR_W-1:0] ep_in_commit_len,
  input  logic              ep_in_ready,
  input  logic              ep_in_commit_ack,
  output logic [2:0]        state,
  output logic [15:0]       pkts_dropped,
  output logic [15:0]       sync_errs,
  output logic [15:0]       ack_timeouts,
  output logic [15:0]       commits
);

  localparam int LW            = ADDR_W + 1;
  localparam int PKT_W         = $clog2(PKT_LEN + 1);
  localparam int IDLE_W        = $clog2(FLUSH_IDLE + 1);
  localparam int TO_W          = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam int MAX_START_OCC = (2 ** FIFO_AW) - PKT_LEN;

  bridge_state_t     state_q;
  bridge_state_t     state_d;

  logic              fifo_wr;
  logic              fifo_rd;
  logic              fifo_empty;
  logic [7:0]        fifo_q;
  logic [FIFO_AW:0]  fifo_level;
  logic [FIFO_AW:0]  occ_now;

  logic              gate_open;
  logic [PKT_W-1:0]  pkt_cnt;
  logic              start_evt;
  logic              start_sync;
  logic              has_room;
  logic              start_ok;
  logic              start_drop;
  logic              sync_evt;
  logic              body_wr;

  logic [ADDR_W-1:0] cnt;
  logic [LW-1:0]     len;
  logic [LW-1:0]     req_len;
  logic [LW-1:0]     eff_len;
  logic              last_byte;
  logic              flush_go;
  logic              ack_s;
  logic              ack_d;
  logic              ack_fall;
  logic              timeout_hit;
  logic [IDLE_W-1:0] idle_cnt;
  logic [TO_W-1:0]   wait_cnt;

  ts_byte_fifo #(
    .AW (FIFO_AW)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .wr_en   (fifo_wr),
    .wr_data (ts_data),
    .rd_en   (fifo_rd),
    .rd_data (fifo_q),
    .level   (fifo_level),
    .empty   (fifo_empty)
  );

  // A packet is admitted only if all of it fits, counting a byte leaving the FIFO this cycle.
  assign occ_now    = fifo_level - {{FIFO_AW{1'b0}}, fifo_rd};
  assign has_room   = int'(occ_now) <= MAX_START_OCC;
  assign start_evt  = ts_dval && ts_strt;
  assign start_sync = start_evt && (ts_data == TS_SYNC);
  assign start_ok   = start_sync && has_room;
  assign start_drop = start_sync && !has_room;
  assign sync_evt   = start_evt && (gate_open || (ts_data != TS_SYNC));
  assign body_wr    = ts_dval && !ts_strt && gate_open;
  assign fifo_wr    = start_ok || body_wr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      gate_open <= 1'b0;
      pkt_cnt   <= '0;
    end else if (start_ok) begin
      gate_open <= 1'b1;
      pkt_cnt   <= PKT_W'(1);
    end else if (start_drop || sync_evt) begin
      gate_open <= 1'b0;
    end else if (body_wr) begin
      pkt_cnt <= pkt_cnt + 1'b1;
      if (pkt_cnt == PKT_W'(PKT_LEN - 1)) gate_open <= 1'b0;
    end
  end

  // Buffer length is taken from commit_len only on the first byte of each buffer.
  assign req_len     = (commit_len == '0) ? {1'b1, {ADDR_W{1'b0}}} : {1'b0, commit_len};
  assign eff_len     = (cnt == '0) ? req_len : len;
  assign last_byte   = ({1'b0, cnt} == (eff_len - 1'b1));
  assign flush_go    = flush_en && (cnt != '0) && (idle_cnt >= IDLE_W'(FLUSH_IDLE));
  assign ack_fall    = ack_d && !ack_s;
  assign timeout_hit = (wait_cnt == TO_W'(ACK_TIMEOUT - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty && ep_in_ready) state_d = ST_READ;
        else if (flush_go)              state_d = ST_COMMIT;
      end
      ST_READ:     state_d = ST_WRITE;
      ST_WRITE:    state_d = last_byte ? ST_COMMIT : ST_IDLE;
      ST_COMMIT:   state_d = ST_WAIT_ACK;
      ST_WAIT_ACK: if (ack_fall || timeout_hit) state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    fifo_rd          = 1'b0;
    ep_in_wren       = 1'b0;
    ep_in_addr       = '0;
    ep_in_data       = '0;
    ep_in_commit     = 1'b0;
    ep_in_commit_len = '0;
    case (state_q)
      ST_IDLE:   fifo_rd = !fifo_empty && ep_in_ready;
      ST_WRITE: begin
        ep_in_wren = 1'b1;
        ep_in_addr = cnt;
        ep_in_data = fifo_q;
      end
      ST_COMMIT: begin
        ep_in_commit     = 1'b1;
        ep_in_commit_len = len[ADDR_W-1:0];
      end
      default: ;
    endcase
  end

  assign state = state_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt      <= '0;
      len      <= '0;
      wait_cnt <= '0;
    end else begin
      case (state_q)
        ST_IDLE: if (state_d == ST_COMMIT) len <= {1'b0, cnt};
        ST_WRITE: begin
          if (cnt == '0) len <= req_len;
          if (!last_byte) cnt <= cnt + 1'b1;
        end
        ST_COMMIT: begin
          cnt      <= '0;
          wait_cnt <= '0;
        end
        ST_WAIT_ACK: wait_cnt <= wait_cnt + 1'b1;
        default: ;
      endcase
    end
  end

  // Ack is synchronised twice so the falling-edge detect sees only registered values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ack_s    <= 1'b0;
      ack_d    <= 1'b0;
      idle_cnt <= '0;
    end else begin
      ack_s <= ep_in_commit_ack;
      ack_d <= ack_s;
      if (fifo_rd || (state_q == ST_COMMIT))     idle_cnt <= '0;
      else if (idle_cnt != IDLE_W'(FLUSH_IDLE)) idle_cnt <= idle_cnt + 1'b1;
    end
  end

`ifdef TS_BRIDGE_STATS_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pkts_dropped <= '0;
      sync_errs    <= '0;
      ack_timeouts <= '0;
      commits      <= '0;
    end else begin
      if (start_drop) pkts_dropped <= pkts_dropped + 16'd1;
      if (sync_evt)   sync_errs    <= sync_errs + 16'd1;
      if ((state_q == ST_WAIT_ACK) && timeout_hit && !ack_fall)
        ack_timeouts <= ack_timeouts + 16'd1;
      if (state_q == ST_COMMIT) commits <= commits + 16'd1;
    end
  end
`else
  assign pkts_dropped = '0;
  assign sync_errs    = '0;
  assign ack_timeouts = '0;
  assign commits      = '0;
`endif

endmodule

// File: tb/tb_ts_usb_bridge.sv
// Directed bench for ts_usb_bridge: packet-level model plus per-cycle endpoint scoreboard.
module tb_ts_usb_bridge;

  localparam int ADDR_W      = 11;
  localparam int FIFO_AW     = 9;
  localparam int PKT_LEN     = 188;
  localparam int ACK_TIMEOUT = 7;
  localparam int FLUSH_IDLE  = 4096;
  localparam int DEPTH       = 1 << FIFO_AW;

  logic              clk;
  logic              reset_n;
  logic              ts_strt;
  logic              ts_dval;
  logic [7:0]        ts_data;
  logic [ADDR_W-1:0] commit_len;
  logic              flush_en;
  logic [ADDR_W-1:0] ep_in_addr;
  logic [7:0]        ep_in_data;
  logic              ep_in_wren;
  logic              ep_in_commit;
  logic [ADDR_W-1:0] ep_in_commit_len;
  logic              ep_in_ready;
  logic              ep_in_commit_ack;
  logic [2:0]        state;
  logic [15:0]       pkts_dropped;
  logic [15:0]       sync_errs;
  logic [15:0]       ack_timeouts;
  logic [15:0]       commits;

  ts_usb_bridge #(
    .ADDR_W      (ADDR_W),
    .FIFO_AW     (FIFO_AW),
    .PKT_LEN     (PKT_LEN),
    .ACK_TIMEOUT (ACK_TIMEOUT),
    .FLUSH_IDLE  (FLUSH_IDLE)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .ts_strt          (ts_strt),
    .ts_dval          (ts_dval),
    .ts_data          (ts_data),
    .commit_len       (commit_len),
    .flush_en         (flush_en),
    .ep_in_addr       (ep_in_addr),
    .ep_in_data       (ep_in_data),
    .ep_in_wren       (ep_in_wren),
    .ep_in_commit     (ep_in_commit),
    .ep_in_commit_len (ep_in_commit_len),
    .ep_in_ready      (ep_in_ready),
    .ep_in_commit_ack (ep_in_commit_ack),
    .state            (state),
    .pkts_dropped     (pkts_dropped),
    .sync_errs        (sync_errs),
    .ack_timeouts     (ack_timeouts),
    .commits          (commits)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Stimulus-owned model state: accepted bytes in order, and expected statistics.
  logic [7:0] exp_mem [0:8191];
  int  wr_idx = 0;
  bit  m_open = 0;
  int  m_cnt = 0;
  int  m_drop = 0;
  int  m_sync = 0;
  int  m_to = 0;
  int  exp_commits = 0;

  // Scoreboard-owned state.
  int  rd_idx = 0;
  int  buf_pos = 0;
  int  model_len = 0;
  bit  commit_due = 0;
  int  last_commit_len = -1;

  task automatic check_output(input string name, input longint actual, input longint expected);
    n_checks++;
    if (actual == expected) n_pass++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  function automatic int exp_stat(input int v);
`ifdef TS_BRIDGE_STATS_EN
    return v & 16'hffff;
`else
    return 0 * v;
`endif
  endfunction

  always @(negedge clk) begin
    if (!reset_n) begin
      rd_idx     = wr_idx;
      buf_pos    = 0;
      commit_due = 0;
    end else begin
      if (commit_due) check_output("commit_after_last_wren", ep_in_commit, 1);
      if (ep_in_commit) begin
        if (commit_due) begin
          check_output("commit_len_full", ep_in_commit_len, model_len % (1 << ADDR_W));
        end else begin
          check_output("flush_enabled", flush_en, 1);
          check_output("flush_len", ep_in_commit_len, buf_pos);
        end
        last_commit_len = int'(ep_in_commit_len);
        buf_pos = 0;
      end
      commit_due = 0;
      if (ep_in_wren) begin
        check_output("wren_with_data_pending", (wr_idx - rd_idx) > 0, 1);
        if (wr_idx > rd_idx) begin
          if (buf_pos == 0) model_len = (commit_len == 0) ? (1 << ADDR_W) : int'(commit_len);
          check_output("wr_data", ep_in_data, exp_mem[rd_idx]);
          check_output("wr_addr", ep_in_addr, buf_pos);
          rd_idx++;
          buf_pos++;
          if (buf_pos == model_len) commit_due = 1;
        end
      end
    end
  end

  task automatic apply_stimulus(input logic [7:0] first, input int n, input int seed);
    logic [7:0] b;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      b = (i == 0) ? first : 8'(seed + i * 7);
      ts_dval = 1'b1;
      ts_strt = (i == 0);
      ts_data = b;
      if (i == 0) begin
        if (m_open || b != 8'h47) m_sync++;
        if (b == 8'h47 && (DEPTH - (wr_idx - rd_idx)) >= PKT_LEN) begin
          m_open = 1;
          m_cnt  = 0;
        end else begin
          if (b == 8'h47) m_drop++;
          m_open = 0;
        end
      end
      if (m_open) begin
        exp_mem[wr_idx] = b;
        wr_idx++;
        m_cnt++;
        if (m_cnt == PKT_LEN) m_open = 0;
      end
    end
    @(posedge clk);
    #1;
    ts_dval = 1'b0;
    ts_strt = 1'b0;
    ts_data = 8'h00;
  endtask

  task automatic wait_commit(input bit give_ack, input int budget,
                             output int wait_cycles, output int delay);
    int n = 0;
    wait_cycles = 0;
    @(negedge clk);
    while (!ep_in_commit && n < budget) begin
      @(negedge clk);
      n++;
    end
    delay = n;
    exp_commits++;
    check_output("commit_seen", ep_in_commit, 1);
    if (ep_in_commit) begin
      if (give_ack) ep_in_commit_ack = 1'b1;
      @(negedge clk);
      while (state == 3'd4 && wait_cycles < 50) begin
        wait_cycles++;
        if (give_ack && wait_cycles == 2) ep_in_commit_ack = 1'b0;
        @(negedge clk);
      end
      ep_in_commit_ack = 1'b0;
      if (!give_ack) m_to++;
      check_output("back_to_idle", state, 0);
    end
  endtask

  task automatic check_stats(input string tag);
    check_output({tag, "_pkts_dropped"}, pkts_dropped, exp_stat(m_drop));
    check_output({tag, "_sync_errs"},    sync_errs,    exp_stat(m_sync));
    check_output({tag, "_ack_timeouts"}, ack_timeouts, exp_stat(m_to));
    check_output({tag, "_commits"},      commits,      exp_stat(exp_commits));
  endtask

  task automatic check_output_zero(input string tag);
    check_output({tag, "_state"},      state, 0);
    check_output({tag, "_wren"},       ep_in_wren, 0);
    check_output({tag, "_addr"},       ep_in_addr, 0);
    check_output({tag, "_data"},       ep_in_data, 0);
    check_output({tag, "_commit"},     ep_in_commit, 0);
    check_output({tag, "_commit_len"}, ep_in_commit_len, 0);
    check_output({tag, "_stats_sum"},  pkts_dropped + sync_errs + ack_timeouts + commits, 0);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int wc;
    int dly;
    reset_n          = 1'b0;
    ts_strt          = 1'b0;
    ts_dval          = 1'b0;
    ts_data          = 8'h00;
    commit_len       = ADDR_W'(376);
    flush_en         = 1'b0;
    ep_in_ready      = 1'b1;
    ep_in_commit_ack = 1'b0;
    repeat (3) @(negedge clk);
    check_output_zero("reset");
    check_output("reset_fifo_level", dut.u_fifo.level, 0);
    reset_n = 1'b1;
    repeat (2) @(posedge clk);

    $display("[TB] two clean packets, commit_len=376, acked");
    apply_stimulus(8'h47, PKT_LEN, 3);
    apply_stimulus(8'h47, PKT_LEN, 91);
    wait_commit(1'b1, 3000, wc, dly);
    check_output("ack_release_before_timeout", (wc > 0) && (wc < ACK_TIMEOUT), 1);
    check_output("last_commit_len_376", last_commit_len, 376);
    check_output("all_bytes_written_1", rd_idx, wr_idx);
    check_stats("t1");

    $display("[TB] two packets, ack held low");
    apply_stimulus(8'h47, PKT_LEN, 17);
    apply_stimulus(8'h47, PKT_LEN, 201);
    wait_commit(1'b0, 3000, wc, dly);
    check_output("wait_ack_cycles", wc, 7);
    check_output("all_bytes_written_2", rd_idx, wr_idx);
    check_stats("t2");

    $display("[TB] bad start byte");
    apply_stimulus(8'h00, PKT_LEN, 55);
    repeat (100) @(negedge clk);
    check_output("model_sync_errs", m_sync, 1);
    check_output("fifo_level_after_bad_start", dut.u_fifo.level, 0);
    check_stats("t3");

    $display("[TB] three packets with endpoint not ready");
    ep_in_ready = 1'b0;
    apply_stimulus(8'h47, PKT_LEN, 5);
    apply_stimulus(8'h47, PKT_LEN, 77);
    apply_stimulus(8'h47, PKT_LEN, 150);
    repeat (5) @(negedge clk);
    check_output("model_fifo_level", wr_idx - rd_idx, 376);
    check_output("model_pkts_dropped", m_drop, 1);
    check_output("fifo_level_full", dut.u_fifo.level, 376);
    check_stats("t4");
    ep_in_ready = 1'b1;
    wait_commit(1'b1, 3000, wc, dly);
    check_output("all_bytes_written_4", rd_idx, wr_idx);

    $display("[TB] start arriving mid-packet, commit_len=289");
    commit_len = ADDR_W'(289);
    apply_stimulus(8'h47, 101, 33);
    apply_stimulus(8'h47, PKT_LEN, 66);
    wait_commit(1'b1, 3000, wc, dly);
    check_output("model_sync_errs_mid", m_sync, 2);
    check_output("last_commit_len_289", last_commit_len, 289);
    check_output("all_bytes_written_4b", rd_idx, wr_idx);
    check_stats("t4b");

    $display("[TB] idle flush of partial buffer");
    commit_len = ADDR_W'(1024);
    flush_en   = 1'b1;
    apply_stimulus(8'h47, PKT_LEN, 120);
    wait_commit(1'b1, 6000, wc, dly);
    check_output("flush_commit_len_188", last_commit_len, 188);
    check_output("flush_delay_window", (dly >= FLUSH_IDLE) && (dly <= FLUSH_IDLE + 3 * PKT_LEN), 1);
    check_output("all_bytes_written_5", rd_idx, wr_idx);
    check_stats("t5");
    flush_en = 1'b0;

    $display("[TB] reset during WAIT_ACK");
    commit_len = ADDR_W'(376);
    apply_stimulus(8'h47, PKT_LEN, 9);
    apply_stimulus(8'h47, PKT_LEN, 44);
    dly = 0;
    @(negedge clk);
    while (!ep_in_commit && dly < 3000) begin
      @(negedge clk);
      dly++;
    end
    check_output("commit_before_reset", ep_in_commit, 1);
    repeat (2) @(negedge clk);
    check_output("in_wait_ack", state, 4);
    reset_n = 1'b0;
    m_drop = 0;
    m_sync = 0;
    m_to = 0;
    exp_commits = 0;
    #1;
    check_output_zero("midreset");
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (30) @(negedge clk);
    check_output("post_reset_state", state, 0);
    check_output("post_reset_fifo_level", dut.u_fifo.level, 0);
    check_stats("t6");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ts_usb_bridge.md
# ts_usb_bridge

Parametrised successor of the single-stream TS-to-USB proxy. It takes the selected demodulator byte stream (start/valid/data, after the TS selector), buffers whole 188-byte packets in an internal FIFO, and writes them byte-by-byte into a USB IN endpoint buffer. It issues a commit/ack handshake per buffer and adds packet-atomic overflow drop, sync-byte checking and idle flush of partially filled buffers. It sits between the TS selector and the USB endpoint IN buffer.

## Interface
Parameters:
- ADDR_W, 11: endpoint buffer address width; max commit 2^ADDR_W bytes
- FIFO_AW, 9: FIFO address width; depth 2^FIFO_AW bytes; must satisfy 2^FIFO_AW >= 2*PKT_LEN
- PKT_LEN, 188: TS packet length, bytes
- ACK_TIMEOUT, 7: cycles in WAIT_ACK before forced release
- FLUSH_IDLE, 4096: idle cycles before a partial buffer is committed

Ports:
- clk  in  1  single clock
- reset_n  in  1  asynchronous, active-low reset
- ts_strt  in  1  first byte of packet
- ts_dval  in  1  byte valid
- ts_data  in  8  byte
- commit_len  in  ADDR_W  bytes per commit; 0 means 2^ADDR_W
- flush_en  in  1  enables idle flush
- ep_in_addr  out  ADDR_W  write address
- ep_in_data  out  8  write data
- ep_in_wren  out  1  write strobe
- ep_in_commit  out  1  one-cycle commit pulse
- ep_in_commit_len  out  ADDR_W  length of the committed buffer
- ep_in_ready  in  1  endpoint accepts writes
- ep_in_commit_ack  in  1  endpoint ack; completion is its falling edge
- state  out  3  output FSM state
- pkts_dropped, sync_errs, ack_timeouts, commits  out  16 each  statistics (see Configuration)

## Operation
- Input gate:
  - A byte with ts_dval & ts_strt & data==8'h47 opens a packet only if FIFO free space >= PKT_LEN. Otherwise the whole packet is discarded and pkts_dropped increments.
  - A start byte with data != 8'h47 is discarded and sync_errs increments.
  - Valid bytes outside an open packet are discarded.
  - The packet closes after PKT_LEN bytes.
  - A start arriving mid-packet: sync_errs increments, the partial packet stays in the FIFO, and the new start is evaluated as above.
- Output FSM states: IDLE=0, READ=1, WRITE=2, COMMIT=3, WAIT_ACK=4.
  - IDLE: if FIFO not empty and ep_in_ready, pulse FIFO read and go to READ. Else if flush_en, cnt!=0 and idle_cnt>=FLUSH_IDLE, latch len=cnt and go to COMMIT.
  - READ: FIFO data valid; go to WRITE.
  - WRITE: wren=1, addr=cnt, data=FIFO q. If cnt==len-1, latch len and go to COMMIT; else cnt++ and go to IDLE.
  - COMMIT: ep_in_commit=1, ep_in_commit_len=len, cnt<=0, commits++, go to WAIT_ACK.
  - WAIT_ACK: return to IDLE on a registered ack falling edge. At ACK_TIMEOUT cycles, return to IDLE and increment ack_timeouts.
- len is commit_len sampled when cnt==0 at each byte write; a mid-buffer change takes effect at the next buffer.
- idle_cnt is saturating; it clears on every FIFO read and every commit.
- All counters wrap modulo 2^16.

## Timing
- Reset (async assert, sync deassert expected): all outputs 0, state IDLE, FIFO empty, gate closed, counters 0, ep_in_commit_len 0.
- Reset mid-packet or mid-WAIT_ACK: FIFO contents are lost; no commit is issued.
- FIFO read latency 1 cycle; 3 cycles per byte to the endpoint. Input-to-first-wren latency is 3 cycles plus 1 write cycle.
- Commit pulse occurs 1 cycle after the last wren.
- Simultaneous FIFO write and read on the same cycle is supported.
- Free-space check uses the occupancy including the current cycle's read.
- Ack rising edge without a prior commit is ignored.

## Configuration
- TS_BRIDGE_STATS_EN:
  - Defined: the four statistics counters are implemented.
  - Undefined: the statistics ports are tied to 0 and no counter logic is generated; drop, sync and timeout behaviour is unchanged.

## Structure
- Shared package ts_pkg holds the state encoding constants, TS_SYNC=8'h47 and TS_PKT_LEN=188.
- Sub-module ts_byte_fifo: synchronous FIFO (parameter AW) with 1-cycle read latency and a level output. It is instantiated once.

## Test plan
- Reset, commit_len=376, two clean packets -> 376 wren at addr 0..375, one commit with commit_len_out=376, commits=1.
- Ack held low after commit -> return to IDLE after 7 cycles, ack_timeouts=1, next buffer starts at addr 0.
- FIFO_AW=9, ep_in_ready=0, three packets -> third packet fully dropped, pkts_dropped=1, FIFO level=376.
- Start byte 8'h00 followed by 187 bytes -> nothing written, sync_errs=1.
- flush_en=1, commit_len=1024, one packet then silence -> commit after 4096 idle cycles with commit_len_out=188.
- Assert reset_n low during WAIT_ACK -> outputs 0 immediately, FSM IDLE, counters 0.
